// File: rtl/axi4_frame_reader.sv
// AXI4 read master that streams a stored RGB565 frame from DDR into the
// HDMI-side pixel FIFO. Fixed-length INCR bursts walk the frame and wrap back
// to the start at the end of each frame. A rising edge on frame_start
// restarts the walk at burst 0 once the in-flight burst has finished.
module axi4_frame_reader #(
   parameter int unsigned                AXI_ADDR_WIDTH   = 32,
   parameter int unsigned                AXI_DATA_WIDTH   = 64,
   parameter logic [AXI_ADDR_WIDTH-1:0]  FRAME_BASE_ADDR  = 32'h0100_0000,
   parameter int unsigned                BURST_LEN        = 64,
   parameter int unsigned                BURSTS_PER_FRAME = 300
) (
   input  logic                      clk_100Mhz,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      frame_start,
   input  logic                      fifo_prog_full,
   output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
   output logic                      ARVALID,
   input  logic                      ARREADY,
   output logic [7:0]                ARLEN,
   output logic [2:0]                ARSIZE,
   output logic [1:0]                ARBURST,
   output logic [3:0]                ARCACHE,
   output logic [2:0]                ARPROT,
   input  logic [AXI_DATA_WIDTH-1:0] RDATA,
   input  logic [1:0]                RRESP,
   input  logic                      RLAST,
   input  logic                      RVALID,
   output logic                      RREADY,
   output logic [AXI_DATA_WIDTH-1:0] pix_data,
   output logic                      pix_valid,
   output logic                      frame_end,
   output logic                      rd_err,
   output logic [1:0]                state,
   output logic [8:0]                burst_idx
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ADDR_SEND = 2'd1,
      DATA_RECV = 2'd2,
      NEXT      = 2'd3
   } state_e;

   localparam int unsigned BEAT_W      = $clog2(BURST_LEN);
   // log2 of the bytes covered by one burst; the per-burst address stride
   localparam int unsigned BURST_SHIFT = $clog2(BURST_LEN * (AXI_DATA_WIDTH / 8));
   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
   localparam logic [8:0]        LAST_BURST = 9'(BURSTS_PER_FRAME - 1);

   state_e                      state_q, state_d;
   logic [8:0]                  burst_idx_q, burst_idx_d;
   logic [AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic [BEAT_W-1:0]           beat_cnt_q, beat_cnt_d;
   logic [AXI_DATA_WIDTH-1:0]   pix_data_q, pix_data_d;
   logic                        pix_valid_q, pix_valid_d;
   logic                        rd_err_q, rd_err_d;
   logic                        resync_pending_q, resync_pending_d;
   logic                        frame_start_q, frame_start_d;

   logic beat;
   logic last_burst;
   logic fs_rise;

   assign beat       = (state_q == DATA_RECV) && RVALID;
   assign last_burst = (burst_idx_q == LAST_BURST);
   assign fs_rise    = frame_start && !frame_start_q;

   // State register
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_100Mhz) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: a burst is only launched from IDLE, and only ends on RLAST
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (enable && !fifo_prog_full && !resync_pending_q) state_d = ADDR_SEND;
         ADDR_SEND: if (ARREADY) state_d = DATA_RECV;
         DATA_RECV: if (beat && RLAST) state_d = NEXT;
         NEXT:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Moore outputs decoded from the current state
   always_comb begin
      ARVALID   = (state_q == ADDR_SEND);
      RREADY    = (state_q == DATA_RECV);
      frame_end = (state_q == NEXT) && last_burst;
   end

   // Datapath: burst address/index, beat forwarding, error and resync tracking
   always_comb begin
      burst_idx_d      = burst_idx_q;
      araddr_d         = araddr_q;
      beat_cnt_d       = beat_cnt_q;
      pix_data_d       = pix_data_q;
      pix_valid_d      = 1'b0;
      rd_err_d         = rd_err_q;
      resync_pending_d = resync_pending_q;
      frame_start_d    = frame_start;
      case (state_q)
         IDLE: begin
            araddr_d   = FRAME_BASE_ADDR + (AXI_ADDR_WIDTH'(burst_idx_q) << BURST_SHIFT);
            beat_cnt_d = '0;
            if (resync_pending_q) begin
               burst_idx_d      = '0;
               resync_pending_d = 1'b0;
            end
         end
         DATA_RECV: begin
            if (beat) begin
               pix_data_d  = RDATA;
               pix_valid_d = 1'b1;
               beat_cnt_d  = beat_cnt_q + 1'b1;
               // Bad response or a burst length mismatch in either direction
               if (RRESP != 2'b00)                       rd_err_d = 1'b1;
               if (RLAST != (beat_cnt_q == LAST_BEAT))   rd_err_d = 1'b1;
            end
         end
         NEXT: burst_idx_d = last_burst ? 9'd0 : burst_idx_q + 1'b1;
         default: ;
      endcase
      // A new frame_start edge outranks the clear in IDLE so it is never lost
      if (fs_rise) resync_pending_d = 1'b1;
   end

   // Datapath registers
   always_ff @(posedge clk_100Mhz) begin
      if (rst) begin
         burst_idx_q      <= '0;
         araddr_q         <= FRAME_BASE_ADDR;
         beat_cnt_q       <= '0;
         pix_data_q       <= '0;
         pix_valid_q      <= 1'b0;
         rd_err_q         <= 1'b0;
         resync_pending_q <= 1'b0;
         frame_start_q    <= 1'b0;
      end else begin
         burst_idx_q      <= burst_idx_d;
         araddr_q         <= araddr_d;
         beat_cnt_q       <= beat_cnt_d;
         pix_data_q       <= pix_data_d;
         pix_valid_q      <= pix_valid_d;
         rd_err_q         <= rd_err_d;
         resync_pending_q <= resync_pending_d;
         frame_start_q    <= frame_start_d;
      end
   end

   assign ARADDR    = araddr_q;
   assign ARLEN     = 8'(BURST_LEN - 1);
   assign ARSIZE    = 3'b011;
   assign ARBURST   = 2'b01;
   assign ARCACHE   = 4'b1111;
   assign ARPROT    = 3'b010;
   assign pix_data  = pix_data_q;
   assign pix_valid = pix_valid_q;
   assign rd_err    = rd_err_q;
   assign state     = state_q;
   assign burst_idx = burst_idx_q;

endmodule

// File: tb/tb_axi4_frame_reader.sv
// Directed bench for axi4_frame_reader: a scripted AXI read slave plus
// hand-computed expected addresses, pixel beats and status flags.
module tb_axi4_frame_reader;

   localparam logic [31:0] BASE = 32'h0100_0000;

   logic        clk_100Mhz = 1'b0;
   logic        rst, enable, frame_start, fifo_prog_full;
   logic [31:0] ARADDR;
   logic        ARVALID, ARREADY;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic [3:0]  ARCACHE;
   logic [2:0]  ARPROT;
   logic [63:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST, RVALID, RREADY;
   logic [63:0] pix_data;
   logic        pix_valid, frame_end, rd_err;
   logic [1:0]  state;
   logic [8:0]  burst_idx;

   int errors = 0;
   int checks = 0;
   int fe_cnt = 0;

   axi4_frame_reader dut (
      .clk_100Mhz(clk_100Mhz), .rst(rst), .enable(enable), .frame_start(frame_start),
      .fifo_prog_full(fifo_prog_full),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN),
      .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
      .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .pix_data(pix_data), .pix_valid(pix_valid), .frame_end(frame_end),
      .rd_err(rd_err), .state(state), .burst_idx(burst_idx)
   );

   always #5 clk_100Mhz = ~clk_100Mhz;

   always @(negedge clk_100Mhz) if (frame_end) fe_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] addr_of(input int b);
      return BASE + 32'(b) * 32'd512;
   endfunction

   task automatic do_reset();
      ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; RDATA = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk_100Mhz);
      rst = 1'b0;
   endtask

   // Serves one burst; returns at the negedge where the DUT sits in NEXT.
   task automatic run_burst(input logic [31:0] exp_addr, input int ar_wait,
                            input bit throttle, input int rresp_beat,
                            input int last_beat, input int fs_beat);
      int n = 0;
      while (!ARVALID && n < 200) begin
         @(negedge clk_100Mhz);
         n++;
      end
      if (!ARVALID) begin
         check("arvalid_timeout", 64'(ARVALID), 64'd1);
         return;
      end
      check("araddr", 64'(ARADDR), 64'(exp_addr));
      for (int i = 0; i < ar_wait; i++) begin
         ARREADY = 1'b0;
         @(negedge clk_100Mhz);
         check("arvalid_hold", 64'(ARVALID), 64'd1);
         check("araddr_hold", 64'(ARADDR), 64'(exp_addr));
      end
      ARREADY = 1'b1;
      @(negedge clk_100Mhz);
      ARREADY = 1'b0;
      check("arvalid_drop", 64'(ARVALID), 64'd0);
      for (int b = 0; b <= last_beat; b++) begin
         if (b == fs_beat) frame_start = 1'b1;
         RVALID = 1'b1;
         RDATA  = {exp_addr, 32'(b)};
         RLAST  = (b == last_beat);
         RRESP  = (b == rresp_beat) ? 2'b10 : 2'b00;
         check("rready", 64'(RREADY), 64'd1);
         @(negedge clk_100Mhz);
         check("pix_valid", 64'(pix_valid), 64'd1);
         check("pix_data", pix_data, {exp_addr, 32'(b)});
         RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
         if (throttle && b != last_beat) begin
            @(negedge clk_100Mhz);
            check("pix_idle", 64'(pix_valid), 64'd0);
         end
      end
      check("rready_off", 64'(RREADY), 64'd0);
   endtask

   initial begin
      enable = 1'b0; frame_start = 1'b0; fifo_prog_full = 1'b0;
      do_reset();

      // Reset state and constant AR fields
      check("rst_state", 64'(state), 64'd0);
      check("rst_burst_idx", 64'(burst_idx), 64'd0);
      check("rst_araddr", 64'(ARADDR), 64'(BASE));
      check("rst_arvalid", 64'(ARVALID), 64'd0);
      check("rst_rready", 64'(RREADY), 64'd0);
      check("rst_pix", {pix_data[62:0], pix_valid}, 64'd0);
      check("rst_flags", {62'd0, frame_end, rd_err}, 64'd0);
      check("ar_const", {44'd0, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT}, {44'd0, 8'd63, 3'b011, 2'b01, 4'b1111, 3'b010});

      // One full frame: addresses step by 512, frame_end only after burst 299
      enable = 1'b1;
      for (int b = 0; b < 300; b++) begin
         run_burst(addr_of(b), 0, 1'b0, -1, 63, -1);
         check("frame_end", 64'(frame_end), 64'(b == 299));
      end
      check("last_addr", 64'(addr_of(299)), 64'h0102_5600);
      @(negedge clk_100Mhz);
      check("frame_end_pulse", 64'(frame_end), 64'd0);
      run_burst(BASE, 0, 1'b0, -1, 63, -1);
      check("frame_end_count", 64'(fe_cnt), 64'd1);

      // FIFO back-pressure in IDLE, then raised mid-burst
      fifo_prog_full = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_100Mhz);
         check("full_no_ar", 64'(ARVALID), 64'd0);
      end
      fifo_prog_full = 1'b0;
      @(negedge clk_100Mhz);
      check("full_release_ar", 64'(ARVALID), 64'd1);
      fifo_prog_full = 1'b1;
      run_burst(addr_of(1), 0, 1'b0, -1, 63, -1);
      fifo_prog_full = 1'b0;

      // ARREADY held low for 10 cycles
      run_burst(addr_of(2), 10, 1'b0, -1, 63, -1);
      run_burst(addr_of(3), 0, 1'b0, -1, 63, -1);
      run_burst(addr_of(4), 0, 1'b0, -1, 63, -1);

      // frame_start edge inside burst 5 with throttled data
      run_burst(addr_of(5), 0, 1'b1, -1, 63, 20);
      frame_start = 1'b0;
      run_burst(BASE, 0, 1'b0, -1, 63, -1);

      // frame_start edge coinciding with NEXT: resync beats the increment
      frame_start = 1'b1;
      @(negedge clk_100Mhz);
      frame_start = 1'b0;
      run_burst(BASE, 0, 1'b0, -1, 63, -1);

      // Error reporting: bad RRESP, sticky flag, early RLAST
      check("err_clear", 64'(rd_err), 64'd0);
      run_burst(addr_of(1), 0, 1'b0, 3, 63, -1);
      check("err_rresp", 64'(rd_err), 64'd1);
      run_burst(addr_of(2), 0, 1'b0, -1, 63, -1);
      check("err_sticky", 64'(rd_err), 64'd1);
      do_reset();
      check("err_rst", 64'(rd_err), 64'd0);
      check("err_rst_idx", 64'(burst_idx), 64'd0);
      run_burst(BASE, 0, 1'b0, -1, 62, -1);
      check("err_short", 64'(rd_err), 64'd1);
      enable = 1'b0;
      do_reset();
      check("err_rst2", 64'(rd_err), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi4_frame_reader.md
Name: axi4_frame_reader

Overview:
- AXI4 read master that fetches the stored 320x240 RGB565 frame from DDR in fixed 64-beat bursts.
- Forwards each 64-bit beat (4 pixels) into the HDMI-side pixel FIFO.
- Read-direction counterpart of the camera-to-DDR write path; uses the same frame base address and burst geometry.
- Loops over the frame continuously while enabled.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI address width.
- AXI_DATA_WIDTH, 64, AXI data width (8 bytes per beat).
- FRAME_BASE_ADDR, 32'h0100_0000, DDR frame start; must be 512-byte aligned.
- BURST_LEN, 64, beats per burst (ARLEN = BURST_LEN-1).
- BURSTS_PER_FRAME, 300, bursts per frame (300 x 512 B = 153600 B).

Ports:
- clk_100Mhz  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  level; reader issues bursts only while high.
- frame_start  in  1  level or pulse; rising edge (detected internally) requests resync to burst 0.
- fifo_prog_full  in  1  downstream FIFO; low guarantees room for at least BURST_LEN words.
- ARADDR  out  32  burst address.
- ARVALID  out  1  address valid.
- ARREADY  in  1  address ready.
- ARLEN  out  8  constant 63.
- ARSIZE  out  3  constant 3'b011.
- ARBURST  out  2  constant 2'b01 (INCR).
- ARCACHE  out  4  constant 4'b1111.
- ARPROT  out  3  constant 3'b010.
- RDATA  in  64  read data.
- RRESP  in  2  read response.
- RLAST  in  1  last beat.
- RVALID  in  1  data valid.
- RREADY  out  1  data ready.
- pix_data  out  64  beat to FIFO din.
- pix_valid  out  1  FIFO wr_en.
- frame_end  out  1  one-cycle pulse after the last beat of burst 299.
- rd_err  out  1  sticky error flag.
- state  out  2  FSM state, for ILA.
- burst_idx  out  9  current burst index 0..299, for ILA.

Behaviour:
- Reset values (synchronous, rst high at clk_100Mhz edge):
  - state = IDLE, burst_idx = 0, ARADDR = FRAME_BASE_ADDR.
  - ARVALID = 0, RREADY = 0, pix_data = 0, pix_valid = 0, frame_end = 0, rd_err = 0, resync_pending = 0.
- Reset mid-burst abandons the transaction. The AXI interconnect is reset by the same rst.
- State encoding: IDLE = 0, ADDR_SEND = 1, DATA_RECV = 2, NEXT = 3.
- IDLE:
  - If resync_pending: burst_idx <= 0 and resync_pending clears.
  - ARADDR <= FRAME_BASE_ADDR + (burst_idx << 9), using 32-bit unsigned math.
  - Go to ADDR_SEND when enable && !fifo_prog_full && !resync_pending.
- ADDR_SEND:
  - ARVALID = 1; ARADDR is held stable until ARVALID && ARREADY.
  - On the handshake cycle: go to DATA_RECV; ARVALID is 0 from the next cycle.
  - ARVALID never drops before the handshake.
- DATA_RECV:
  - RREADY = 1 throughout.
  - Each RVALID && RREADY beat: pix_data <= RDATA and pix_valid <= 1 on the next cycle (latency 1). pix_valid = 0 on cycles with no beat.
  - An internal 6-bit beat counter increments per beat.
  - RRESP != 2'b00 on any beat sets rd_err; the data is still forwarded.
  - RLAST with beat count != 63, or beat 63 without RLAST, sets rd_err.
  - The burst terminates only on RLAST; then go to NEXT and RREADY = 0.
- NEXT (one cycle):
  - If burst_idx == BURSTS_PER_FRAME-1: burst_idx <= 0 and frame_end = 1 for this cycle. Otherwise burst_idx++.
  - Go to IDLE.
- Last burst address: 0x0100_0000 + 299*512 = 0x0102_5600.
  - Bursts are 512-aligned and never cross a 4 KB boundary.
- frame_start:
  - A rising edge at any time sets resync_pending.
  - An in-flight burst always completes; it is never aborted.
  - If the rising edge coincides with NEXT, resync wins: the next burst is burst 0.
- enable low: stops new bursts after the current one; burst_idx is retained.
- fifo_prog_full is sampled only in IDLE. Once a burst starts, RREADY stays high regardless.
- rd_err clears only on rst.

Test Plan:
- Reset, enable=1, fifo_prog_full=0, slave with ARREADY=1 and 64 beats RDATA=beat index -> ARADDR=0x0100_0000 and ARLEN=63; pix_valid high 64 times carrying 0..63, each 1 cycle after its beat; then ARADDR=0x0100_0200.
- Run 300 bursts -> frame_end pulses exactly once, 1 cycle after RLAST of burst 299 (ARADDR 0x0102_5600); next ARADDR=0x0100_0000.
- fifo_prog_full=1 held in IDLE -> ARVALID stays 0. Drop it -> ARVALID on the next cycle. Raise it mid-burst -> all 64 beats still accepted.
- ARREADY held low 10 cycles -> ARVALID and ARADDR stable throughout; handshake on cycle 11.
- frame_start edge during burst 5, RVALID throttled 50% -> burst 5 completes with all 64 beats; next ARADDR=0x0100_0000.
- RRESP=2'b10 on beat 3, or RLAST on beat 62 -> rd_err=1 and stays 1; it clears only after rst.
